// File: rtl/demux_1to4.sv
// Routes one input word per cycle into one of four single-entry channel buffers; one-cycle latency in to out_valid.
// Stalls the producer via in_ready only when the target buffer is full and its consumer is not draining it.
module demux_1to4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [7:0]       count
);

  logic [3:0][WIDTH-1:0] ybuf;
  logic [3:0]            full;
  logic                  accept;

  // A full buffer can still take a word when its consumer drains it this same cycle.
  assign in_ready = !full[in_sel] || out_ready[in_sel];
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ybuf  <= '0;
      full  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept && (in_sel == 2'(i))) begin
          ybuf[i] <= in_data;
          full[i] <= 1'b1;
        end else if (out_ready[i]) begin
          full[i] <= 1'b0;
        end
      end
      if (accept) begin
        count <= count + 8'd1;
      end
    end
  end

  assign out_valid = full;
  assign y0        = ybuf[0];
  assign y1        = ybuf[1];
  assign y2        = ybuf[2];
  assign y3        = ybuf[3];

endmodule
